alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU among R requesters (cores or vector lanes).
- Round-robin arbitration, valid/ready request and response handshakes.
- Operands and opcode are registered and held stable for an op-dependent number of settle cycles, so MUL/DIV/MOD long paths meet timing.
- Captures the result and the cout/zero/neg/overflow flags and returns them tagged with the requester id.
- Sits between the core issue stages and the single shared ALU instance.

Parameters:
- N, 32, datapath width.
- R, 4, number of requesters (2..8).
- MUL_LAT, 2, settle cycles for op 3'b010.
- DIV_LAT, 4, settle cycles for ops 3'b011 and 3'b100.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  R  per-requester request valid.
- req_ready  out  R  per-requester accept; at most one bit high.
- req_a  in  R*N  operand A; requester i uses slice [i*N +: N].
- req_b  in  R*N  operand B, same slicing.
- req_op  in  R*3  ALU control code, slice [i*3 +: 3].
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  $clog2(R)  index of the requester being answered.
- rsp_result  out  N  captured result.
- rsp_flags  out  4  {cout, zero, neg, overflow}.
- alu_a, alu_b  out  N  to shared ALU operands.
- alu_control  out  3  to shared ALU.
- alu_result  in  N  from ALU.
- alu_cout, alu_zero, alu_neg, alu_overflow  in  1  from ALU.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=R-1, all registers 0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, alu_a=0, alu_b=0, alu_control=0.
  - Reset mid-operation drops the in-flight op; no response is issued for it.
- Arbitration (IDLE only):
  - Grant the first i with req_valid[i]=1, searching rr_ptr+1, rr_ptr+2, … modulo R.
  - req_ready[i]=1 combinationally for the granted i only; req_ready=0 in every other state.
  - On handshake: latch a, b, op and id; set rr_ptr=i; go to EXEC.
- Settle count by op:
  - 000 add, 001 sub, 101 shl, 110 passB, 111 cmp: 1 cycle.
  - 010 mul: MUL_LAT cycles.
  - 011 div, 100 mod: DIV_LAT cycles.
- EXEC/WAIT:
  - alu_a, alu_b and alu_control are driven from the latched registers and held constant until capture.
  - A down-counter is loaded with settle-1.
  - When the counter reaches 0, capture alu_result and the flags into rsp_* registers and go to RESP.
- Divide by zero (op 011 or 100 with b==0):
  - Bypass the ALU wait.
  - Go to RESP after one EXEC cycle with result=0, flags=4'b0101 (zero=1, overflow=1).
- RESP:
  - rsp_valid=1; rsp_id, rsp_result and rsp_flags are stable until rsp_ready=1.
  - On handshake, the next state is IDLE. No grant occurs in the same cycle, so minimum occupancy is settle+2 cycles per op.
- Requester independence: a requester may drop req_valid before it is granted without side effects. Latched operands are immune to req_* changes after the grant.
- Opcode mapping: an op code outside the 3-bit range is impossible; all 8 codes are legal.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_SHL, OP_PASSB, OP_CMP.
  - Enum arb_state_t {IDLE, EXEC, RESP}.
  - Flag bit indices.
- One natural sub-module: rr_arbiter (parameter R; inputs req and ptr; outputs one-hot grant and encoded index), purely combinational.
- The FSM, counter and capture logic stay in alu_share_arbiter.

Test Plan:
- Single add: requester 0 sends a=5, b=7, op=000 with rsp_ready=1.
  - Expect req_ready[0] in cycle 0, rsp_valid in cycle 2.
  - Expect rsp_id=0, rsp_result=12, flags zero=0.
- Round-robin: all four requesters are held valid continuously.
  - Expect grant order 0,1,2,3,0.
  - Each response carries the correct id and the sum of its own operands.
- Divide latency: requester 2 sends a=100, b=7, op=011 with DIV_LAT=4.
  - Expect rsp_valid exactly 5 cycles after the grant, with result=14.
  - alu_a, alu_b and alu_control must not change between the grant and the capture.
- Divide by zero: a=9, b=0, op=100.
  - Expect rsp_valid 2 cycles after the grant, with result=0 and flags=4'b0101.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid rises.
  - rsp_* outputs stay stable and req_ready stays 0.
  - After release, the next grant follows 1 cycle later.
- Async reset: assert rst_n=0 during WAIT of a mul.
  - All outputs go to 0 immediately, with no response for the dropped op.
  - After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: opcodes, FSM states, flag layout.
package alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MOD   = 3'b100;
  localparam logic [2:0] OP_SHL   = 3'b101;
  localparam logic [2:0] OP_PASSB = 3'b110;
  localparam logic [2:0] OP_CMP   = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;

  // Bit positions inside the 4-bit {cout, zero, neg, overflow} flag word.
  localparam int FLAG_OVF  = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_COUT = 3;

  localparam logic [3:0] DIV0_FLAGS = (4'b1 << FLAG_ZERO) | (4'b1 << FLAG_OVF);

  function automatic int settle_cycles(input logic [2:0] op, input int mul_lat, input int div_lat);
    case (op)
      OP_MUL:         return mul_lat;
      OP_DIV, OP_MOD: return div_lat;
      default:        return 1;
    endcase
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the issuing cores and the ALU sharing arbiter.
interface alu_share_arbiter_if #(
  parameter int N  = 32,
  parameter int R  = 4,
  parameter int IW = (R > 1) ? $clog2(R) : 1
);
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic [R*3-1:0] req_op;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [N-1:0]   rsp_result;
  logic [3:0]     rsp_flags;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping modulo R.
module rr_arbiter #(
  parameter int R  = 4,
  parameter int IW = (R > 1) ? $clog2(R) : 1
) (
  input  logic [R-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [R-1:0]  grant,
  output logic [IW-1:0] idx
);

  always_comb begin : pick
    logic found;
    int   cand;
    // NOTE: every output gets a default before the search so no path leaves a latch.
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= R; k++) begin
      cand = (int'(ptr) + k) % R;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU among R requesters; operands are held for an
// op-dependent settle time before the result and flags are captured and returned.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int N       = 32,
  parameter int R       = 4,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus,
  output logic [N-1:0]        alu_a,
  output logic [N-1:0]        alu_b,
  output logic [2:0]          alu_control,
  input  logic [N-1:0]        alu_result,
  input  logic                alu_cout,
  input  logic                alu_zero,
  input  logic                alu_neg,
  input  logic                alu_overflow
);

  localparam int IW      = (R > 1) ? $clog2(R) : 1;
  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;

  arb_state_t    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] lat_id;
  logic [CW-1:0] cnt;
  logic          div0;
  logic [R-1:0]  grant;
  logic [IW-1:0] gidx;
  logic [N-1:0]  sel_a;
  logic [N-1:0]  sel_b;
  logic [2:0]    sel_op;
  logic [3:0]    alu_flags;
  logic          rsp_valid_q;
  logic [IW-1:0] rsp_id_q;
  logic [N-1:0]  rsp_result_q;
  logic [3:0]    rsp_flags_q;

  rr_arbiter #(.R(R), .IW(IW)) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx)
  );

  assign sel_a  = bus.req_a[int'(gidx)*N +: N];
  assign sel_b  = bus.req_b[int'(gidx)*N +: N];
  assign sel_op = bus.req_op[int'(gidx)*3 +: 3];

  always_comb begin
    alu_flags            = '0;
    alu_flags[FLAG_COUT] = alu_cout;
    alu_flags[FLAG_ZERO] = alu_zero;
    alu_flags[FLAG_NEG]  = alu_neg;
    alu_flags[FLAG_OVF]  = alu_overflow;
  end

  // Grants are only offered while idle; the handshake itself is req_valid & req_ready.
  assign bus.req_ready  = (state == IDLE) ? grant : '0;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;

  // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= IW'(R - 1);
      lat_id       <= '0;
      cnt          <= '0;
      div0         <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_control  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            alu_a       <= sel_a;
            alu_b       <= sel_b;
            alu_control <= sel_op;
            lat_id      <= gidx;
            rr_ptr      <= gidx;
            cnt         <= CW'(settle_cycles(sel_op, MUL_LAT, DIV_LAT) - 1);
            div0        <= is_div(sel_op) && (sel_b == '0);
            state       <= EXEC;
          end
        end
        EXEC: begin
          // A zero divisor skips the settle wait and reports a fixed result.
          if (div0 || cnt == '0) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= lat_id;
            rsp_result_q <= div0 ? '0 : alu_result;
            rsp_flags_q  <= div0 ? DIV0_FLAGS : alu_flags;
            state        <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level reference model.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int N       = 32;
  localparam int R       = 4;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.N(N), .R(R)) bus ();

  logic [N-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_control;
  logic         alu_cout, alu_zero, alu_neg, alu_overflow;

  alu_share_arbiter #(.N(N), .R(R), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_control  (alu_control),
    .alu_result   (alu_result),
    .alu_cout     (alu_cout),
    .alu_zero     (alu_zero),
    .alu_neg      (alu_neg),
    .alu_overflow (alu_overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference ALU: returns {cout, zero, neg, overflow, result}.
  function automatic logic [N+3:0] alu_eval(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
    logic [N-1:0] r;
    logic [N:0]   w;
    logic         c, v;
    r = '0; w = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD:   begin w = {1'b0, a} + {1'b0, b}; r = w[N-1:0]; c = w[N];
                      v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]); end
      OP_SUB:   begin r = a - b; c = (a >= b);
                      v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]); end
      OP_MUL:   r = a * b;
      OP_DIV:   r = (b != '0) ? a / b : '1;
      OP_MOD:   r = (b != '0) ? a % b : a;
      OP_SHL:   r = a << b[4:0];
      OP_PASSB: r = b;
      default:  r = N'(a < b);
    endcase
    return {c, (r == '0), r[N-1], v, r};
  endfunction

  function automatic int lat_of(input logic [2:0] op);
    if (op == 3'b010) return MUL_LAT;
    if (op == 3'b011 || op == 3'b100) return DIV_LAT;
    return 1;
  endfunction

  // The external ALU only produces a correct answer once its inputs have been
  // stable for the op's settle time; earlier it returns the inverted value.
  logic [2*N+2:0] alu_last;
  int             alu_age = 0;
  always @(negedge clk) begin
    if ({alu_a, alu_b, alu_control} !== alu_last) begin
      alu_last = {alu_a, alu_b, alu_control};
      alu_age  = 1;
    end else if (alu_age < 100) begin
      alu_age++;
    end
  end

  always_comb begin
    logic [N+3:0] v;
    v = alu_eval(alu_a, alu_b, alu_control);
    if (alu_age < lat_of(alu_control)) v = ~v;
    {alu_cout, alu_zero, alu_neg, alu_overflow, alu_result} = v;
  end

  logic [R-1:0] hs;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) hs <= '0;
    else        hs <= bus.req_valid & bus.req_ready;
  end

  // Reference model: one op in flight, response due a fixed number of cycles after grant.
  bit           m_idle = 1'b1;
  int           m_ptr = R - 1;
  int           ncyc = 0;
  int           due = 0;
  int           p_id = 0;
  logic [N-1:0] p_a, p_b;
  logic [2:0]   p_op;
  bit           p_div0;
  int           grant_log[$];
  int           grant_cyc_log[$];
  int           n_rsp = 0;
  int           rise_cyc = 0;
  int           last_hs_cyc = 0;
  logic [N-1:0] last_result;
  logic [3:0]   last_flags;
  bit           prev_valid = 1'b0;

  always @(negedge clk) begin : monitor
    logic [R-1:0] exp_ready;
    logic [N+3:0] e;
    int           pick, c;
    #1;
    ncyc++;
    if (!rst_n) begin
      m_idle = 1'b1; m_ptr = R - 1; prev_valid = 1'b0;
      check("rst_req_ready", bus.req_ready, '0);
      check("rst_rsp_valid", bus.rsp_valid, '0);
      check("rst_rsp_id", bus.rsp_id, '0);
      check("rst_rsp_result", bus.rsp_result, '0);
      check("rst_rsp_flags", bus.rsp_flags, '0);
      check("rst_alu_a", alu_a, '0);
      check("rst_alu_b", alu_b, '0);
      check("rst_alu_control", alu_control, '0);
    end else begin
      if (bus.rsp_valid && !prev_valid) rise_cyc = ncyc;
      prev_valid = bus.rsp_valid;
      exp_ready = '0;
      pick = -1;
      if (m_idle) begin
        for (int k = 1; k <= R; k++) begin
          c = (m_ptr + k) % R;
          if (pick < 0 && bus.req_valid[c]) pick = c;
        end
      end
      if (pick >= 0) exp_ready[pick] = 1'b1;
      check("req_ready", bus.req_ready, exp_ready);
      if (m_idle) begin
        check("rsp_valid_idle", bus.rsp_valid, 1'b0);
        if (pick >= 0) begin
          p_id   = pick;
          p_a    = bus.req_a[pick*N +: N];
          p_b    = bus.req_b[pick*N +: N];
          p_op   = bus.req_op[pick*3 +: 3];
          p_div0 = (p_op == 3'b011 || p_op == 3'b100) && (p_b == '0);
          due    = ncyc + (p_div0 ? 2 : lat_of(p_op) + 1);
          m_ptr  = pick;
          m_idle = 1'b0;
          grant_log.push_back(pick);
          grant_cyc_log.push_back(ncyc);
        end
      end else if (ncyc < due) begin
        check("rsp_valid_early", bus.rsp_valid, 1'b0);
        check("alu_a_hold", alu_a, p_a);
        check("alu_b_hold", alu_b, p_b);
        check("alu_control_hold", alu_control, p_op);
      end else begin
        e = p_div0 ? {4'b0101, {N{1'b0}}} : alu_eval(p_a, p_b, p_op);
        check("rsp_valid", bus.rsp_valid, 1'b1);
        check("rsp_id", bus.rsp_id, p_id);
        check("rsp_result", bus.rsp_result, e[N-1:0]);
        check("rsp_flags", bus.rsp_flags, e[N+3:N]);
        if (bus.rsp_ready) begin
          m_idle      = 1'b1;
          n_rsp++;
          last_hs_cyc = ncyc;
          last_result = bus.rsp_result;
          last_flags  = bus.rsp_flags;
        end
      end
    end
  end

  // Stimulus: all drives happen right after a negedge, before the monitor samples.
  bit rand_en = 1'b0;

  task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
    bus.req_valid[i]      = 1'b1;
    bus.req_a[i*N +: N]   = a;
    bus.req_b[i*N +: N]   = b;
    bus.req_op[i*3 +: 3]  = op;
  endtask

  task automatic tick();
    logic [N-1:0] b;
    @(negedge clk);
    for (int i = 0; i < R; i++) if (hs[i]) bus.req_valid[i] = 1'b0;
    if (rand_en) begin
      for (int i = 0; i < R; i++) begin
        if (!bus.req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            b = ($urandom_range(0, 3) == 0) ? '0 : $urandom_range(0, 7) == 0 ? $urandom : N'($urandom_range(1, 300));
            set_req(i, $urandom, b, 3'($urandom_range(0, 7)));
          end
        end else if ($urandom_range(0, 15) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int t = 0;
    while (n_rsp < target && t < budget) begin
      tick(); #2; t++;
    end
    check("wait_rsp", n_rsp >= target, 1'b1);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    bus.req_valid = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int g0, tgt, t;
    logic [N-1:0] saved_result;
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;

    // Single add from requester 0.
    tick();
    g0 = grant_log.size(); tgt = n_rsp + 1;
    set_req(0, 32'd5, 32'd7, OP_ADD);
    wait_rsp(tgt, 20);
    check("t1_grant", grant_log[g0], 0);
    check("t1_latency", rise_cyc - grant_cyc_log[g0], 2);
    check("t1_result", last_result, 32'd12);
    check("t1_flags", last_flags, 4'b0000);

    // Round robin with all requesters continuously valid.
    do_reset();
    g0 = grant_log.size(); tgt = n_rsp + 5; t = 0;
    while (n_rsp < tgt && t < 100) begin
      if (t > 0) tick();
      for (int i = 0; i < R; i++) if (!bus.req_valid[i]) set_req(i, $urandom, $urandom, OP_ADD);
      #2; t++;
    end
    check("t2_done", n_rsp >= tgt, 1'b1);
    for (int k = 0; k < 5; k++) check("t2_order", grant_log[g0+k], k % R);
    tick();
    bus.req_valid = '0;

    // Divide latency.
    tick();
    g0 = grant_log.size(); tgt = n_rsp + 1;
    set_req(2, 32'd100, 32'd7, OP_DIV);
    wait_rsp(tgt, 30);
    check("t3_grant", grant_log[g0], 2);
    check("t3_latency", rise_cyc - grant_cyc_log[g0], DIV_LAT + 1);
    check("t3_result", last_result, 32'd14);

    // Divide by zero bypass.
    tick();
    g0 = grant_log.size(); tgt = n_rsp + 1;
    set_req(1, 32'd9, 32'd0, OP_MOD);
    wait_rsp(tgt, 30);
    check("t4_latency", rise_cyc - grant_cyc_log[g0], 2);
    check("t4_result", last_result, 32'd0);
    check("t4_flags", last_flags, 4'b0101);

    // Backpressure, with another requester waiting meanwhile.
    tick();
    bus.rsp_ready = 1'b0;
    tgt = n_rsp + 1;
    set_req(3, 32'd20, 32'd22, OP_ADD);
    t = 0;
    do begin tick(); #2; t++; end while (!bus.rsp_valid && t < 20);
    check("t5_rsp_rise", bus.rsp_valid, 1'b1);
    saved_result = bus.rsp_result;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 2) set_req(0, 32'd50, 32'd8, OP_SUB);
      #2;
      check("t5_ready_low", bus.req_ready, '0);
      check("t5_result_stable", bus.rsp_result, saved_result);
    end
    tick();
    bus.rsp_ready = 1'b1;
    g0 = grant_log.size();
    wait_rsp(tgt, 10);
    check("t5_result", last_result, 32'd42);
    t = 0;
    while (grant_log.size() == g0 && t < 10) begin tick(); #2; t++; end
    check("t5_next_grant", grant_log[g0], 0);
    check("t5_grant_gap", grant_cyc_log[g0] - last_hs_cyc, 1);
    wait_rsp(tgt + 1, 20);
    check("t5_sub_result", last_result, 32'd42);

    // Random traffic with random backpressure.
    tick();
    rand_en = 1'b1;
    repeat (3000) tick();
    tick();
    rand_en = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    t = 0;
    do begin tick(); #2; t++; end while (!m_idle && t < 50);
    check("rand_drain", m_idle, 1'b1);
    check("rand_activity", n_rsp > 100, 1'b1);

    // Asynchronous reset during a multiply.
    tick();
    set_req(1, 32'd123, 32'd456, OP_MUL);
    tick();
    #2;
    check("t6_busy", m_idle, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_req_ready", bus.req_ready, '0);
    check("t6_rsp_valid", bus.rsp_valid, '0);
    check("t6_rsp_result", bus.rsp_result, '0);
    check("t6_rsp_flags", bus.rsp_flags, '0);
    check("t6_alu_a", alu_a, '0);
    check("t6_alu_b", alu_b, '0);
    check("t6_alu_control", alu_control, '0);
    tick();
    bus.req_valid = '0;
    tick();
    rst_n = 1'b1;
    g0 = grant_log.size(); tgt = n_rsp + 1;
    for (int i = 0; i < R; i++) set_req(i, 32'(i + 1), 32'd10, OP_ADD);
    wait_rsp(tgt, 20);
    check("t6_first_grant", grant_log[g0], 0);
    check("t6_result", last_result, 32'd11);
    tick();
    bus.req_valid = '0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
